// File: rtl/fft_r4_bfly_pipe.sv
`default_nettype none
// =============================================================================
// fft_r4_bfly_pipe : streaming radix-4 DIF butterfly, twiddle multiply on y1..y3
// Revision: 1.0
// =============================================================================
module fft_r4_bfly_pipe #(
  parameter int W    = 16,
  parameter int FRAC = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           inv,
  input  logic           scale,
  input  logic [2*W-1:0] x0,
  input  logic [2*W-1:0] x1,
  input  logic [2*W-1:0] x2,
  input  logic [2*W-1:0] x3,
  input  logic [2*W-1:0] w1,
  input  logic [2*W-1:0] w2,
  input  logic [2*W-1:0] w3,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y0,
  output logic [2*W-1:0] y1,
  output logic [2*W-1:0] y2,
  output logic [2*W-1:0] y3,
  output logic           ovf,
  input  logic           ovf_clr
);
  localparam int BW = W + 2;
  localparam int PW = BW + W;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] MAXV  = SW'((2 ** (W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV  = SW'(-(2 ** (W - 1)));
  localparam logic signed [PW-1:0] RHALF = PW'(2 ** (FRAC - 1));

  // Returns {clipped, value}.
  function automatic logic [W:0] sat(input logic signed [SW-1:0] v);
    if (v > MAXV)      return {1'b1, MAXV[W-1:0]};
    else if (v < MINV) return {1'b1, MINV[W-1:0]};
    else               return {1'b0, v[W-1:0]};
  endfunction

  function automatic logic signed [BW-1:0] quarter(input logic signed [BW-1:0] v);
    logic signed [BW:0] t;
    t = (BW+1)'(v) + (BW+1)'(2);
    return BW'(t >>> 2);
  endfunction

  logic adv, v0_q, v1_q, v2_q, v3_q, ovf_q, ovf_d, clip;
  assign adv       = !v3_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign ovf       = ovf_q;

  // Accepted groups are captured first; the three arithmetic stages follow.
  logic [2*W-1:0] in_x_q [4];
  logic [2*W-1:0] in_w_q [3];
  logic           in_inv_q, in_sc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q     <= 1'b0;
      in_inv_q <= 1'b0;
      in_sc_q  <= 1'b0;
      for (int i = 0; i < 4; i++) in_x_q[i] <= '0;
      for (int k = 0; k < 3; k++) in_w_q[k] <= '0;
    end else if (adv) begin
      v0_q <= in_valid;
      if (in_valid) begin
        in_x_q[0] <= x0; in_x_q[1] <= x1; in_x_q[2] <= x2; in_x_q[3] <= x3;
        in_w_q[0] <= w1; in_w_q[1] <= w2; in_w_q[2] <= w3;
        in_inv_q  <= inv;
        in_sc_q   <= scale;
      end
    end
  end

  logic signed [BW-1:0] xr [4], xi [4];
  for (genvar i = 0; i < 4; i++) begin : g_xext
    assign xr[i] = BW'(signed'(in_x_q[i][2*W-1:W]));
    assign xi[i] = BW'(signed'(in_x_q[i][W-1:0]));
  end

  logic signed [BW-1:0] ar, ai, br, bi, cr, ci, dr, di;
  logic signed [BW-1:0] raw_re [4], raw_im [4], s1_re_d [4], s1_im_d [4];
  always_comb begin
    ar = xr[0] + xr[2];  ai = xi[0] + xi[2];
    br = xr[1] + xr[3];  bi = xi[1] + xi[3];
    cr = xr[0] - xr[2];  ci = xi[0] - xi[2];
    dr = xr[1] - xr[3];  di = xi[1] - xi[3];
    raw_re[0] = ar + br;  raw_im[0] = ai + bi;
    raw_re[2] = ar - br;  raw_im[2] = ai - bi;
    raw_re[1] = in_inv_q ? cr - di : cr + di;
    raw_im[1] = in_inv_q ? ci + dr : ci - dr;
    raw_re[3] = in_inv_q ? cr + di : cr - di;
    raw_im[3] = in_inv_q ? ci - dr : ci + dr;
    for (int i = 0; i < 4; i++) begin
      s1_re_d[i] = in_sc_q ? quarter(raw_re[i]) : raw_re[i];
      s1_im_d[i] = in_sc_q ? quarter(raw_im[i]) : raw_im[i];
    end
  end

  logic signed [BW-1:0] s1_re_q [4], s1_im_q [4];
  logic [2*W-1:0]       s1_w_q [3];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin s1_re_q[i] <= '0; s1_im_q[i] <= '0; end
      for (int k = 0; k < 3; k++) s1_w_q[k] <= '0;
    end else if (adv) begin
      v1_q <= v0_q;
      if (v0_q) begin
        s1_re_q <= s1_re_d;
        s1_im_q <= s1_im_d;
        s1_w_q  <= in_w_q;
      end
    end
  end

  logic signed [PW-1:0] p_rr_d [3], p_ii_d [3], p_ri_d [3], p_ir_d [3];
  for (genvar k = 0; k < 3; k++) begin : g_mul
    logic signed [PW-1:0] wr, wi, vr, vi;
    assign wr = PW'(signed'(s1_w_q[k][2*W-1:W]));
    assign wi = PW'(signed'(s1_w_q[k][W-1:0]));
    assign vr = PW'(s1_re_q[k+1]);
    assign vi = PW'(s1_im_q[k+1]);
    assign p_rr_d[k] = vr * wr;
    assign p_ii_d[k] = vi * wi;
    assign p_ri_d[k] = vr * wi;
    assign p_ir_d[k] = vi * wr;
  end

  logic signed [PW-1:0] p_rr_q [3], p_ii_q [3], p_ri_q [3], p_ir_q [3];
  logic signed [BW-1:0] s2_b0re_q, s2_b0im_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q      <= 1'b0;
      s2_b0re_q <= '0;
      s2_b0im_q <= '0;
      for (int k = 0; k < 3; k++) begin
        p_rr_q[k] <= '0; p_ii_q[k] <= '0; p_ri_q[k] <= '0; p_ir_q[k] <= '0;
      end
    end else if (adv) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_b0re_q <= s1_re_q[0];
        s2_b0im_q <= s1_im_q[0];
        p_rr_q <= p_rr_d; p_ii_q <= p_ii_d; p_ri_q <= p_ri_d; p_ir_q <= p_ir_d;
      end
    end
  end

  logic [W:0] sre [4], sim [4];
  assign sre[0] = sat(SW'(s2_b0re_q));
  assign sim[0] = sat(SW'(s2_b0im_q));
  for (genvar k = 0; k < 3; k++) begin : g_rnd
    logic signed [PW-1:0] rr, ii, ri, ir;
    assign rr = (p_rr_q[k] + RHALF) >>> FRAC;
    assign ii = (p_ii_q[k] + RHALF) >>> FRAC;
    assign ri = (p_ri_q[k] + RHALF) >>> FRAC;
    assign ir = (p_ir_q[k] + RHALF) >>> FRAC;
    assign sre[k+1] = sat(SW'(rr) - SW'(ii));
    assign sim[k+1] = sat(SW'(ri) + SW'(ir));
  end

  assign clip = sre[0][W] | sre[1][W] | sre[2][W] | sre[3][W] |
                sim[0][W] | sim[1][W] | sim[2][W] | sim[3][W];
  // A set in the same cycle as a clear takes priority.
  assign ovf_d = (adv && v2_q && clip) || (ovf_q && !ovf_clr);

  logic [W-1:0] y_re_q [4], y_im_q [4];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q  <= 1'b0;
      ovf_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin y_re_q[i] <= '0; y_im_q[i] <= '0; end
    end else begin
      ovf_q <= ovf_d;
      if (adv) begin
        v3_q <= v2_q;
        if (v2_q) begin
          for (int i = 0; i < 4; i++) begin
            y_re_q[i] <= sre[i][W-1:0];
            y_im_q[i] <= sim[i][W-1:0];
          end
        end
      end
    end
  end

  assign y0 = {y_re_q[0], y_im_q[0]};
  assign y1 = {y_re_q[1], y_im_q[1]};
  assign y2 = {y_re_q[2], y_im_q[2]};
  assign y3 = {y_re_q[3], y_im_q[3]};

endmodule
`default_nettype wire
